// File: rtl/sigmoid_lut_arbiter.sv
// Round-robin arbiter sharing one registered-read sigmoid LUT between NUM_REQ requesters,
// with a drain-then-load mode that lets the table be rewritten without disturbing reads.
module sigmoid_lut_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    input  logic                      load_req_i,
    output logic                      load_active_o,
    input  logic                      load_we_i,
    input  logic [ADDR_W-1:0]         load_addr_i,
    input  logic [DATA_W-1:0]         load_data_i,
    output logic                      lut_en_o,
    output logic                      lut_we_o,
    output logic                      lut_reset_o,
    output logic [ADDR_W-1:0]         lut_addr_o,
    output logic [DATA_W-1:0]         lut_di_o,
    input  logic [DATA_W-1:0]         lut_dout_i
);

    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_SHIFT  = 2;
    localparam int HALF_RANGE = 2 ** (ADDR_W + IDX_SHIFT - 1);
    localparam logic signed [DATA_W:0] X_MIN = (DATA_W + 1)'(-HALF_RANGE);
    localparam logic signed [DATA_W:0] X_MAX = (DATA_W + 1)'(HALF_RANGE - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_LOAD
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_idx_q, s1_idx_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]   s2_id_q, s2_id_d;

    logic [DATA_W-1:0] req_data_a [NUM_REQ];
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   cand_id;
    logic [DATA_W-1:0] gnt_data;
    logic              accept;
    logic              lut_wr;

    // Q8.8 input clamped to [-8, +8) and quantised to 1/64 steps.
    function automatic logic [ADDR_W-1:0] sat_index(input logic [DATA_W-1:0] x);
        logic signed [DATA_W:0] xs;
        logic signed [DATA_W:0] biased;
        xs     = $signed({x[DATA_W-1], x});
        biased = xs - X_MIN;
        if (xs < X_MIN) begin
            sat_index = '0;
        end else if (xs > X_MAX) begin
            sat_index = '1;
        end else begin
            sat_index = ADDR_W'(biased >>> IDX_SHIFT);
        end
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_data_a[i] = req_data_i[i*DATA_W +: DATA_W];
        end
    end

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand_id   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_id = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!gnt_found && req_valid_i[cand_id]) begin
                gnt_found = 1'b1;
                gnt_id    = cand_id;
            end
        end
    end

    assign gnt_data = req_data_a[gnt_id];
    assign accept   = (state_q == ST_RUN) && gnt_found;
    assign lut_wr   = (state_q == ST_LOAD) && load_we_i;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        s1_valid_d = accept;
        s1_idx_d   = s1_idx_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s1_valid_q;
        s2_id_d    = s1_id_q;

        if (accept) begin
            s1_idx_d = sat_index(gnt_data);
            s1_id_d  = gnt_id;
            ptr_d    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end

        case (state_q)
            ST_RUN: begin
                if (load_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!load_req_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_RUN;
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
        end
    end

    // Ready is gated by reset so a held request never sees a grant while reset is low.
    always_comb begin
        req_ready_o = '0;
        if (reset_ni && accept) begin
            req_ready_o = NUM_REQ'(1) << gnt_id;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        if (s2_valid_q) begin
            rsp_valid_o = NUM_REQ'(1) << s2_id_q;
            rsp_data_o  = lut_dout_i;
        end
    end

    // Reads and writes never overlap: LOAD is only entered after both stages are empty.
    always_comb begin
        lut_en_o   = s1_valid_q || lut_wr;
        lut_we_o   = lut_wr;
        lut_addr_o = '0;
        lut_di_o   = '0;
        if (lut_wr) begin
            lut_addr_o = load_addr_i;
            lut_di_o   = load_data_i;
        end else if (s1_valid_q) begin
            lut_addr_o = s1_idx_q;
        end
    end

    assign load_active_o = (state_q == ST_LOAD);
    assign lut_reset_o   = ~reset_ni;

endmodule

// File: doc/sigmoid_lut_arbiter.md
Name: sigmoid_lut_arbiter

Overview:
Shares one sigmoid lookup-table RAM between NUM_REQ neuron requesters. The LUT has a 1024-entry, 16-bit, registered-read port.
- Arbitrates requests round-robin.
- Maps each signed Q8.8 pre-activation to a saturated 10-bit LUT index.
- Pipelines the read and returns each result to the requester that issued it.
- Provides a load mode that sequences LUT writes once in-flight reads have drained.
The block sits between the perceptron neuron array and the sigmoid LUT instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, pre-activation and sigmoid data width (Q8.8 signed in, unsigned Q0.16 out)
ADDR_W, 10, LUT address width (1024 entries)

Ports:
clk_i  in  1  clock; all logic on the rising edge
reset_ni  in  1  asynchronous, active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_data_i  in  NUM_REQ*DATA_W  per-requester pre-activation; slice k belongs to requester k
req_ready_o  out  NUM_REQ  one-hot grant; the transfer happens when valid and ready are both high
rsp_valid_o  out  NUM_REQ  one-hot response strobe, one cycle wide
rsp_data_o  out  DATA_W  sigmoid result; valid while any bit of rsp_valid_o is high
load_req_i  in  1  level request to enter load mode
load_active_o  out  1  high while in LOAD; LUT writes are accepted only then
load_we_i  in  1  write strobe, used in LOAD only
load_addr_i  in  ADDR_W  write address
load_data_i  in  DATA_W  write data
lut_en_o  out  1  LUT enable
lut_we_o  out  1  LUT write enable
lut_reset_o  out  1  LUT output-register clear; held at 0 except in the case noted under Reset
lut_addr_o  out  ADDR_W  LUT address
lut_di_o  out  DATA_W  LUT write data
lut_dout_i  in  DATA_W  LUT read data, valid one cycle after lut_en with we=0

Behaviour:
Reset (reset_ni=0, asynchronous):
- req_ready_o, rsp_valid_o, lut_en_o, lut_we_o and load_active_o go to 0.
- lut_addr_o, lut_di_o and rsp_data_o go to 0.
- State goes to RUN; the round-robin pointer goes to requester 0.
- In-flight reads are discarded; no response is issued after reset is released.

Index mapping (raw signed Q8.8 value x):
- x < -2048 -> index 0.
- x > 2047 -> index 1023.
- Otherwise index = (x + 2048) >> 2, which covers [-8.0, +8.0) at a step of 1/64.

States:
- RUN: grant at most one requester per cycle.
  - Grant goes to the first valid requester at or after the pointer, searching upward with wrap-around.
  - After a grant, the pointer moves to the granted index + 1, wrapping at NUM_REQ.
  - With no valid requester, req_ready_o=0 and the pointer holds.
  - req_ready_o is combinational from req_valid_i and the pointer. It never asserts for a requester whose valid is low.
  - load_req_i=1 -> DRAIN. Requests presented in that same cycle are still granted normally.
- DRAIN: req_ready_o=0. Wait until pipeline stages 1 and 2 are empty, then go to LOAD.
- LOAD: load_active_o=1 and req_ready_o=0.
  - Each load_we_i=1 cycle drives lut_en_o=1, lut_we_o=1, lut_addr_o=load_addr_i and lut_di_o=load_data_i combinationally.
  - load_req_i=0 -> RUN on the next cycle.

Pipeline (accept in cycle T):
- Stage 1: at the T edge, register the index and the requester id, and set stage-1 valid.
  - During T+1 this drives lut_en_o=1, lut_we_o=0 and lut_addr_o=index.
- Stage 2: the LUT registers its data at the T+1 edge; the id moves to stage 2.
- Response: in cycle T+2, rsp_data_o = lut_dout_i combinationally. rsp_valid_o has only the bit for that id set.
- Latency is 2 cycles from handshake to response. Throughput is 1 request per cycle.
- Responses have no backpressure and come out in grant order.

Other rules:
- Load writes are never issued while a read is in flight; the DRAIN state guarantees this.
- load_we_i outside LOAD is ignored.
- A requester that holds valid without being granted keeps its data stable (standard valid/ready rule). The arbiter does not check this.

Test Plan:
- Single request: requester 0 sends 0x0000 -> lut_addr_o=512 in T+1, rsp_valid_o=0001 in T+2, rsp_data_o = the LUT content at 512.
- Saturation: inputs 0x8000, 0xF800, 0x07FF and 0x7FFF -> indices 0, 0, 1023 and 1023 respectively.
- Round-robin, NUM_REQ=4, all four valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses follow in the same order, 2 cycles later, one per cycle.
- Load sequencing: load_req_i rises with two reads in flight -> both responses return. load_active_o rises once the pipeline is empty. Write 0x1234 to address 5 -> a later request of 0xF814 (index 5) returns 0x1234.
- Blocked requests: in DRAIN and LOAD, req_ready_o stays 0 with all requests valid. After load_req_i drops, granting resumes from the saved pointer.
- Async reset mid-pipeline: reset_ni pulled low between edges with reads in flight -> outputs go to 0 immediately; after release no rsp_valid_o is seen and the first grant goes to requester 0.
